io_bus_master: RTL and testbench

Single-outstanding initiator for the 6-bit peripheral I/O bus that the GPIO ports (Port_B and siblings) respond to. It accepts register-access commands over a valid/ready interface, sequences the address, strobe and data lines, captures read data qualified by the responder's output enable, and returns a response. It sits between the core/debug command source and the shared I/O bus.

---
 rtl/io_bus_pkg.sv | 35 +++
 rtl/io_bus_master.sv | 172 +++++++++++++++++
 tb/tb_io_bus_master.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/io_bus_pkg.sv
// Shared definitions for the 6-bit peripheral I/O bus: op codes, master state encoding,
// bus widths and the read-modify-write helper.
package io_bus_pkg;

    localparam int unsigned IO_ADR_W  = 6;
    localparam int unsigned IO_DATA_W = 8;

    // Only the low half of the I/O space is bit-addressable.
    localparam logic [IO_ADR_W-1:0] RMW_MAX_ADR = 6'h1F;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_READ   = 2'b01,
        OP_SETBIT = 2'b10,
        OP_CLRBIT = 2'b11
    } io_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRd   = 2'b01,
        StWr   = 2'b10,
        StRsp  = 2'b11
    } io_state_e;

    function automatic logic [IO_DATA_W-1:0] rmw_value(
        input io_op_e               op,
        input logic [IO_DATA_W-1:0] val,
        input logic [2:0]           idx
    );
        logic [IO_DATA_W-1:0] mask;
        mask = {{(IO_DATA_W-1){1'b0}}, 1'b1} << idx;
        return (op == OP_SETBIT) ? (val | mask) : (val & ~mask);
    endfunction

endpackage

// File: rtl/io_bus_master.sv
// Single-outstanding initiator for the peripheral I/O bus.
// Optional feature: define IO_RMW_EN to build SETBIT/CLRBIT read-modify-write support.
module io_bus_master
    import io_bus_pkg::*;
#(
    parameter int unsigned RD_WAIT = 0
) (
    input  logic                 cp2,
    input  logic                 ireset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [IO_ADR_W-1:0]  cmd_adr,
    input  logic [IO_DATA_W-1:0] cmd_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IO_DATA_W-1:0] rsp_data,
    output logic                 rsp_err,
    output logic [IO_ADR_W-1:0]  io_adr,
    output logic                 io_re,
    output logic                 io_we,
    output logic [IO_DATA_W-1:0] io_wdata,
    input  logic [IO_DATA_W-1:0] io_rdata,
    input  logic                 io_rd_en
);

    localparam logic [2:0] RD_WAIT_CNT = 3'(RD_WAIT);

    io_state_e            state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [IO_DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 rsp_valid_q;
    logic [IO_ADR_W-1:0]  io_adr_q, io_adr_d;
    logic [IO_DATA_W-1:0] io_wdata_q, io_wdata_d;
    logic                 io_re_q, io_we_q;

`ifdef IO_RMW_EN
    io_op_e               op_q, op_d;
    logic [2:0]           idx_q, idx_d;
    logic [IO_DATA_W-1:0] rmw_wdata;
`endif

    assign cmd_ready = (state_q == StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign io_adr    = io_adr_q;
    assign io_re     = io_re_q;
    assign io_we     = io_we_q;
    assign io_wdata  = io_wdata_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        io_adr_d   = io_adr_q;
        io_wdata_d = io_wdata_q;
`ifdef IO_RMW_EN
        op_d      = op_q;
        idx_d     = idx_q;
        rmw_wdata = rmw_value(op_q, io_rdata, idx_q);
`endif

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
`ifdef IO_RMW_EN
                    op_d  = io_op_e'(cmd_op);
                    idx_d = cmd_data[2:0];
`endif
                    case (io_op_e'(cmd_op))
                        OP_WRITE: begin
                            state_d    = StWr;
                            io_adr_d   = cmd_adr;
                            io_wdata_d = cmd_data;
                        end
                        OP_READ: begin
                            state_d  = StRd;
                            io_adr_d = cmd_adr;
                            cnt_d    = RD_WAIT_CNT;
                        end
                        default: begin
`ifdef IO_RMW_EN
                            if (cmd_adr <= RMW_MAX_ADR) begin
                                state_d  = StRd;
                                io_adr_d = cmd_adr;
                                cnt_d    = RD_WAIT_CNT;
                            end else begin
                                state_d   = StRsp;
                                rsp_err_d = 1'b1;
                            end
`else
                            state_d   = StRsp;
                            rsp_err_d = 1'b1;
`endif
                        end
                    endcase
                end
            end

            StRd: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    // Last read cycle: data is taken at the edge that closes it.
                    state_d    = StRsp;
                    rsp_data_d = io_rd_en ? io_rdata : '0;
                    rsp_err_d  = ~io_rd_en;
`ifdef IO_RMW_EN
                    if (op_q != OP_READ && io_rd_en) begin
                        state_d    = StWr;
                        io_wdata_d = rmw_wdata;
                        rsp_data_d = rmw_wdata;
                    end
`endif
                end
            end

            StWr: begin
                state_d = StRsp;
            end

            StRsp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Strobes and rsp_valid are registered copies of the next-state decode.
    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            io_adr_q    <= '0;
            io_wdata_q  <= '0;
            io_re_q     <= 1'b0;
            io_we_q     <= 1'b0;
`ifdef IO_RMW_EN
            op_q        <= OP_WRITE;
            idx_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= (state_d == StRsp);
            io_adr_q    <= io_adr_d;
            io_wdata_q  <= io_wdata_d;
            io_re_q     <= (state_d == StRd);
            io_we_q     <= (state_d == StWr);
`ifdef IO_RMW_EN
            op_q        <= op_d;
            idx_q       <= idx_d;
`endif
        end
    end

endmodule

// File: tb/tb_io_bus_master.sv
// Scoreboard bench for io_bus_master with a small Port_B-like responder at 0x03..0x05.
module tb_io_bus_master;
    import io_bus_pkg::*;

    localparam int unsigned RD_WAIT = 3;
    localparam int RL = 1 + RD_WAIT;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         acc;
        int         lat;
    } exp_t;

    logic       cp2;
    logic       ireset;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic [5:0] cmd_adr;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [5:0] io_adr;
    logic       io_re, io_we;
    logic [7:0] io_wdata, io_rdata;
    logic       io_rd_en;

    logic [7:0] mem [64];
    exp_t       sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         re_total = 0;
    int         we_total = 0;
    logic [5:0] last_wr_adr = '0;
    logic [7:0] last_wr_data = '0;
    logic       in_rsp = 1'b0;

    io_bus_master #(.RD_WAIT(RD_WAIT)) dut (
        .cp2(cp2), .ireset(ireset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_adr(cmd_adr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .io_adr(io_adr), .io_re(io_re), .io_we(io_we), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_rd_en(io_rd_en)
    );

    initial cp2 = 1'b0;
    always #5 cp2 = ~cp2;
    always @(posedge cp2) cyc <= cyc + 1;

    // Combinational responder; registers written on the strobe edge.
    assign io_rdata = mem[io_adr];
    assign io_rd_en = io_re && (io_adr >= 6'h03) && (io_adr <= 6'h05);
    always @(posedge cp2) if (io_we) mem[io_adr] <= io_wdata;

    task automatic check(input string nm, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    // Monitor: bus strobe bookkeeping and response scoreboard.
    always @(negedge cp2) begin
        exp_t e;
        if (!ireset) begin
            in_rsp = 1'b0;
        end else begin
            if (io_re || io_we) check("re_we_exclusive", int'(io_re & io_we), 0);
            if (io_re) re_total++;
            if (io_we) begin
                we_total++;
                last_wr_adr  = io_adr;
                last_wr_data = io_wdata;
            end
            if (rsp_valid && !in_rsp) begin
                in_rsp = 1'b1;
                if (sb.size() == 0) check("unexpected_rsp", 1, 0);
                else check("rsp_latency", cyc - sb[0].acc, sb[0].lat);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rsp_data", int'(rsp_data), int'(e.data));
                    check("rsp_err", int'(rsp_err), int'(e.err));
                end
                in_rsp = 1'b0;
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [5:0] adr, input logic [7:0] data,
                         output int acc);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge cp2); #1;
            n++;
        end
        check("cmd_ready_before_issue", int'(cmd_ready), 1);
        cmd_op    = op;
        cmd_adr   = adr;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(posedge cp2); #1;
        cmd_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_rsp(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge cp2);
            n++;
        end
        check({nm, "_rsp_done"}, sb.size(), 0);
        #1;
    endtask

    task automatic do_cmd(input string nm, input logic [1:0] op, input logic [5:0] adr,
                          input logic [7:0] data, input logic [7:0] exp_d, input logic exp_e,
                          input int lat, input int exp_re, input int exp_we,
                          input logic [7:0] exp_wdata);
        int re0, we0, acc;
        exp_t e;
        re0 = re_total;
        we0 = we_total;
        issue(op, adr, data, acc);
        e.data = exp_d; e.err = exp_e; e.acc = acc; e.lat = lat;
        sb.push_back(e);
        wait_rsp(nm);
        @(negedge cp2);
        check({nm, "_re_cycles"}, re_total - re0, exp_re);
        check({nm, "_we_cycles"}, we_total - we0, exp_we);
        if (exp_we != 0) begin
            check({nm, "_wr_adr"}, int'(last_wr_adr), int'(adr));
            check({nm, "_wr_data"}, int'(last_wr_data), int'(exp_wdata));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int acc;
        exp_t e;
        logic [7:0] portb_final;
        ireset = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_adr = '0; cmd_data = '0; rsp_ready = 1'b1;
        #2 ireset = 1'b0;
        @(negedge cp2);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_data", int'(rsp_data), 0);
        check("rst_rsp_err", int'(rsp_err), 0);
        check("rst_io_adr", int'(io_adr), 0);
        check("rst_io_re", int'(io_re), 0);
        check("rst_io_we", int'(io_we), 0);
        check("rst_io_wdata", int'(io_wdata), 0);
        @(posedge cp2); #1 ireset = 1'b1;
        @(negedge cp2);

        do_cmd("wr_ddb", OP_WRITE, 6'h04, 8'hFF, 8'h00, 1'b0, 1, 0, 1, 8'hFF);
        check("ddb_value", int'(mem[4]), 8'hFF);
        do_cmd("wr_portb", OP_WRITE, 6'h05, 8'hA5, 8'h00, 1'b0, 1, 0, 1, 8'hA5);
        do_cmd("rd_portb", OP_READ, 6'h05, 8'h00, 8'hA5, 1'b0, RL, RL, 0, 8'h00);
        do_cmd("rd_noresp", OP_READ, 6'h3F, 8'h00, 8'h00, 1'b1, RL, RL, 0, 8'h00);
        do_cmd("wr_ddb2", OP_WRITE, 6'h04, 8'h3C, 8'h00, 1'b0, 1, 0, 1, 8'h3C);
        do_cmd("rd_ddb2", OP_READ, 6'h04, 8'h00, 8'h3C, 1'b0, RL, RL, 0, 8'h00);
`ifdef IO_RMW_EN
        do_cmd("wr_clr", OP_WRITE, 6'h05, 8'h00, 8'h00, 1'b0, 1, 0, 1, 8'h00);
        do_cmd("setbit3", OP_SETBIT, 6'h05, 8'h03, 8'h08, 1'b0, RL + 1, RL, 1, 8'h08);
        do_cmd("clrbit3", OP_CLRBIT, 6'h05, 8'h03, 8'h00, 1'b0, RL + 1, RL, 1, 8'h00);
        do_cmd("wr_ff", OP_WRITE, 6'h05, 8'hFF, 8'h00, 1'b0, 1, 0, 1, 8'hFF);
        do_cmd("clrbit7", OP_CLRBIT, 6'h05, 8'h07, 8'h7F, 1'b0, RL + 1, RL, 1, 8'h7F);
        do_cmd("setbit_hi", OP_SETBIT, 6'h25, 8'h01, 8'h00, 1'b1, 0, 0, 0, 8'h00);
        do_cmd("setbit_20", OP_SETBIT, 6'h20, 8'h01, 8'h00, 1'b1, 0, 0, 0, 8'h00);
        do_cmd("setbit_1f", OP_SETBIT, 6'h1F, 8'h00, 8'h00, 1'b1, RL, RL, 0, 8'h00);
        check("portb_after_rmw", int'(mem[5]), 8'h7F);
        portb_final = 8'h7F;
`else
        do_cmd("setbit_off", OP_SETBIT, 6'h05, 8'h03, 8'h00, 1'b1, 0, 0, 0, 8'h00);
        check("portb_unchanged", int'(mem[5]), 8'hA5);
        do_cmd("clrbit_off", OP_CLRBIT, 6'h04, 8'h02, 8'h00, 1'b1, 0, 0, 0, 8'h00);
        check("ddb_unchanged", int'(mem[4]), 8'h3C);
        portb_final = 8'hA5;
`endif

        // Response stall: rsp_ready low for 10 cycles.
        rsp_ready = 1'b0;
        issue(OP_READ, 6'h04, 8'h00, acc);
        e.data = 8'h3C; e.err = 1'b0; e.acc = acc; e.lat = RL;
        sb.push_back(e);
        repeat (RL) @(negedge cp2);
        for (int i = 0; i < 10; i++) begin
            @(negedge cp2);
            check("stall_rsp_valid", int'(rsp_valid), 1);
            check("stall_rsp_data", int'(rsp_data), 8'h3C);
            check("stall_cmd_ready", int'(cmd_ready), 0);
        end
        @(posedge cp2); #1 rsp_ready = 1'b1;
        wait_rsp("stall");

        // Reset during RD: strobe drops at once, no response follows.
        issue(OP_READ, 6'h05, 8'h00, acc);
        @(negedge cp2);
        check("mid_rst_re_before", int'(io_re), 1);
        #1 ireset = 1'b0;
        #1;
        check("mid_rst_re_dropped", int'(io_re), 0);
        check("mid_rst_cmd_ready", int'(cmd_ready), 1);
        @(posedge cp2); @(posedge cp2); #1 ireset = 1'b1;
        repeat (10) @(negedge cp2);
        check("post_rst_rsp_valid", int'(rsp_valid), 0);
        check("post_rst_cmd_ready", int'(cmd_ready), 1);
        check("post_rst_io_re", int'(io_re), 0);

        do_cmd("rd_after_rst", OP_READ, 6'h05, 8'h00, portb_final, 1'b0, RL, RL, 0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
